// File: rtl/bitseq_pkg.sv
// Shared types for the bitstream frame sequencer: FSM state encoding and the
// completed-frame counter width.
package bitseq_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_RUN  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } seq_state_e;

    // True while a launched frame is owned by the streamer.
    function automatic logic is_run_state(input seq_state_e st);
        return (st == ST_WAIT_RUN) || (st == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/bitstream_frame_sequencer_if.sv
// Host-side valid/ready frame port of the bitstream frame sequencer.
interface bitstream_frame_sequencer_if #(
    parameter int DATALEN = 10
);
    logic [DATALEN-1:0] s_data;
    logic               s_valid;
    logic               s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/bitseq_fifo.sv
// Synchronous frame buffer with registered level; DEPTH must be a power of two
// so the pointers wrap by natural overflow.
module bitseq_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == '0);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/bitstream_frame_sequencer.sv
// Buffers host frames and launches them one at a time into the bitstreamer,
// with an inter-frame gap. Optional watchdog: define SEQ_WATCHDOG_EN.
module bitstream_frame_sequencer
    import bitseq_pkg::*;
#(
    parameter int DATALEN     = 10,
    parameter int CNTLEN      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    bitstream_frame_sequencer_if.slave    host,
    input  logic [CNTLEN-1:0]             phase_in,
    input  logic                          enable,
    output logic [DATALEN-1:0]            datain,
    output logic [CNTLEN-1:0]             phase_delay,
    output logic                          start,
    input  logic                          sysrun,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [FRAME_CNT_W-1:0]        frame_cnt,
    output logic                          wdog_err
);
    localparam int GAPW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam seq_state_e POST_FRAME_ST = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    seq_state_e             state_r;
    seq_state_e             state_nxt_s;
    logic [DATALEN-1:0]     fifo_rd_data_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   push_s;
    logic                   pop_s;
    logic [GAPW-1:0]        gap_cnt_r;
    logic                   gap_done_s;
    logic                   frame_done_s;
    logic                   wdog_timeout_s;
    logic [DATALEN-1:0]     datain_r;
    logic [CNTLEN-1:0]      phase_delay_r;
    logic                   start_r;
    logic                   busy_r;
    logic [FRAME_CNT_W-1:0] frame_cnt_r;

    assign host.s_ready = !fifo_full_s;
    assign push_s       = host.s_valid && !fifo_full_s;
    assign pop_s        = (state_r == ST_LOAD);
    assign frame_done_s = (state_r == ST_WAIT_DONE) && !sysrun;
    assign gap_done_s   = (32'(gap_cnt_r) == GAP_CYCLES - 1);

    bitseq_fifo #(
        .WIDTH (DATALEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (host.s_data),
        .pop     (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);

    logic [WDW-1:0] wdog_cnt_r;
    logic           wdog_err_r;

    // A normal completion on the limit cycle takes precedence over the timeout.
    assign wdog_timeout_s = is_run_state(state_r) && !frame_done_s &&
                            (32'(wdog_cnt_r) == WDOG_CYCLES - 1);
    assign wdog_err       = wdog_err_r;

    // Watchdog counter, cleared whenever the frame leaves the streamer's hands.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_r <= '0;
            wdog_err_r <= 1'b0;
        end else begin
            if (is_run_state(state_r) && !wdog_timeout_s) begin
                wdog_cnt_r <= wdog_cnt_r + WDW'(1);
            end else begin
                wdog_cnt_r <= '0;
            end
            if (wdog_timeout_s) wdog_err_r <= 1'b1;
        end
    end
`else
    assign wdog_timeout_s = 1'b0;
    assign wdog_err       = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && !fifo_empty_s) state_nxt_s = ST_LOAD;
                else                         state_nxt_s = ST_IDLE;
            end
            ST_LOAD:  state_nxt_s = ST_START;
            ST_START: state_nxt_s = ST_WAIT_RUN;
            ST_WAIT_RUN: begin
                if (wdog_timeout_s) state_nxt_s = POST_FRAME_ST;
                else if (sysrun)    state_nxt_s = ST_WAIT_DONE;
                else                state_nxt_s = ST_WAIT_RUN;
            end
            ST_WAIT_DONE: begin
                if (frame_done_s || wdog_timeout_s) state_nxt_s = POST_FRAME_ST;
                else                                state_nxt_s = ST_WAIT_DONE;
            end
            ST_GAP: begin
                if (gap_done_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_GAP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, gap counter and registered streamer-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            gap_cnt_r     <= '0;
            datain_r      <= '0;
            phase_delay_r <= '0;
            start_r       <= 1'b0;
            busy_r        <= 1'b0;
            frame_cnt_r   <= '0;
        end else begin
            state_r   <= state_nxt_s;
            start_r   <= (state_nxt_s == ST_START);
            busy_r    <= (state_nxt_s != ST_IDLE);
            gap_cnt_r <= (state_r == ST_GAP) ? gap_cnt_r + GAPW'(1) : '0;
            if (pop_s) begin
                datain_r      <= fifo_rd_data_s;
                phase_delay_r <= phase_in;
            end
            if (frame_done_s) frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
        end
    end

    assign datain      = datain_r;
    assign phase_delay = phase_delay_r;
    assign start       = start_r;
    assign busy        = busy_r;
    assign frame_cnt   = frame_cnt_r;

endmodule
